neuron_layer: RTL and testbench

- Parametrised successor to the single-neuron datapath/controller pair.
- Computes M neurons in parallel over one shared stream of d signed fixed-point inputs (N bits, Q fraction bits), with per-neuron weights.
- Scales, saturates and applies a selectable activation, then presents M registered results with a one-cycle done pulse.
- Sits between the input/weight feeders and the next layer or the result store.

---
 rtl/neuron_layer.sv | 116 +++++++++++
 tb/tb_neuron_layer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer.sv
// M parallel fixed-point neurons over a shared d-sample input stream; done pulses 2 cycles after the d-th accept.
// Optional build macro NEURON_LAYER_SAT_EN: saturate the scaled sum to N bits instead of wrapping.
module neuron_layer #(
  parameter int N = 16,
  parameter int Q = 8,
  parameter int d = 4,
  parameter int M = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           st,
  input  logic [1:0]     mode,
  input  logic [N-1:0]   x,
  input  logic           x_valid,
  output logic           x_ready,
  input  logic [M*N-1:0] weight,
  output logic           busy,
  output logic [M*N-1:0] data_out,
  output logic           done
);

  localparam int AW = 2*N + $clog2(d) + 1;
  localparam int CW = $clog2(d + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [N-1:0] MAXV     = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINV     = {1'b1, {(N-1){1'b0}}};
  // 1.0 in QN.Q is not representable when Q == N-1; clamp it to the signed max.
  localparam logic [N-1:0] STEP_ONE = (Q >= N-1) ? MAXV : (N'(1) << Q);

  logic [1:0]             state;
  logic [CW-1:0]          count;
  logic [1:0]             mode_q;
  logic signed [AW-1:0]   acc  [M];
  logic signed [2*N-1:0]  prod [M];
  logic [N-1:0]           v    [M];
  logic [M*N-1:0]         res_all;
`ifdef NEURON_LAYER_SAT_EN
  localparam logic signed [AW-1:0] R_MAX = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW-1:0] R_MIN = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};
  logic signed [AW-1:0]   r    [M];
`endif

  assign busy    = (state != IDLE);
  assign x_ready = (state == ACC);

  always_comb begin
    for (int k = 0; k < M; k++) begin
      prod[k] = $signed(x) * $signed(weight[k*N +: N]);
    end
  end

  always_comb begin
    res_all = '0;
    for (int k = 0; k < M; k++) begin
`ifdef NEURON_LAYER_SAT_EN
      r[k] = acc[k] >>> Q;
      if (r[k] > R_MAX)
        v[k] = MAXV;
      else if (r[k] < R_MIN)
        v[k] = MINV;
      else
        v[k] = r[k][N-1:0];
`else
      // Low N bits of (acc >>> Q) are exactly this slice.
      v[k] = acc[k][Q +: N];
`endif
      case (mode_q)
        2'b01:   res_all[k*N +: N] = v[k][N-1] ? '0 : v[k];
        2'b10:   res_all[k*N +: N] = (!v[k][N-1] && (v[k] != '0)) ? STEP_ONE : '0;
        default: res_all[k*N +: N] = v[k];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      mode_q   <= 2'b00;
      done     <= 1'b0;
      data_out <= '0;
      for (int k = 0; k < M; k++) acc[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (st) begin
            state  <= ACC;
            count  <= '0;
            mode_q <= mode;
            for (int k = 0; k < M; k++) acc[k] <= '0;
          end
        end
        ACC: begin
          if (x_valid) begin
            for (int k = 0; k < M; k++)
              acc[k] <= acc[k] + {{(AW-2*N){prod[k][2*N-1]}}, prod[k]};
            count <= count + 1'b1;
            if (count == CW'(d - 1)) state <= FIN;
          end
        end
        FIN: begin
          data_out <= res_all;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer.sv
// Randomized and directed checks of neuron_layer against an arithmetic reference model.
module tb_neuron_layer;

  localparam int N = 16;
  localparam int Q = 8;
  localparam int D = 4;
  localparam int M = 2;

  logic           clk = 1'b0;
  logic           rst, st, x_valid, x_ready, busy, done;
  logic [1:0]     mode;
  logic [N-1:0]   x;
  logic [M*N-1:0] weight, data_out;

  int xs [D];
  int ws [D][M];
  int gaps [D];
  int tests = 0;
  int fails = 0;

  neuron_layer #(.N(N), .Q(Q), .d(D), .M(M)) dut (
    .clk(clk), .rst(rst), .st(st), .mode(mode), .x(x), .x_valid(x_valid),
    .x_ready(x_ready), .weight(weight), .busy(busy), .data_out(data_out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint out_of(int k);
    logic signed [N-1:0] f;
    f = data_out[k*N +: N];
    return longint'(f);
  endfunction

  // Expected neuron output from plain integer arithmetic.
  function automatic longint ref_neuron(int k, int m);
    longint s, r, v;
    s = 0;
    for (int i = 0; i < D; i++) s += longint'(xs[i]) * longint'(ws[i][k]);
    r = s >>> Q;
`ifdef NEURON_LAYER_SAT_EN
    v = (r > 32767) ? 32767 : (r < -32768) ? -32768 : r;
`else
    v = r & 64'hFFFF;
    if (v >= 32768) v -= 65536;
`endif
    case (m)
      1:       return (v < 0) ? 0 : v;
      2:       return (v > 0) ? ((Q >= N-1) ? 32767 : (longint'(1) << Q)) : 0;
      default: return v;
    endcase
  endfunction

  // Starts at a negedge, ends at the negedge where done is observed.
  task automatic run_op(input int m, input bit st_mid, input bit chk_total);
    int edges, since;
    edges = 0;
    st = 1'b1; mode = 2'(m);
    @(negedge clk);
    st = 1'b0; mode = 2'($urandom);
    chk("busy_acc", busy, 1);
    for (int i = 0; i < D; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        x_valid = 1'b0; x = N'($urandom); weight = ($urandom);
        @(negedge clk); edges++;
      end
      chk("x_ready_acc", x_ready, 1);
      x_valid = 1'b1;
      x = N'(xs[i]);
      weight = {N'(ws[i][1]), N'(ws[i][0])};
      st = st_mid && (i == 1);
      @(negedge clk); edges++;
    end
    x_valid = 1'b0; st = 1'b0; x = N'($urandom); weight = ($urandom);
    since = 1;
    chk("fin_no_done", done, 0);
    chk("fin_x_ready", x_ready, 0);
    chk("fin_busy", busy, 1);
    while (!done && since < 8) begin
      @(negedge clk); since++;
    end
    chk("done_latency", since, 2);
    if (chk_total) chk("done_total", edges + since, D + 2);
    chk("done_busy", busy, 0);
    for (int k = 0; k < M; k++) chk($sformatf("data_out%0d_m%0d", k, m), out_of(k), ref_neuron(k, m));
  endtask

  task automatic set_scenario1();
    xs[0] = 256; xs[1] = 512; xs[2] = -256; xs[3] = 128;
    for (int i = 0; i < D; i++) begin
      ws[i][0] = 256; ws[i][1] = -256; gaps[i] = 0;
    end
  endtask

  task automatic idle_check(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (j == 0) chk("done_pulse_width", done, 0);
    end
  endtask

  initial begin
    longint held;
    int ndone;
    rst = 1'b1; st = 1'b0; mode = 2'b00; x = '0; x_valid = 1'b0; weight = '0;
    repeat (2) @(negedge clk);
    chk("rst_data_out", longint'(data_out), 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x_ready", x_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    set_scenario1();
    run_op(0, 0, 1);
    chk("lin_out0", out_of(0), 640);
    chk("lin_out1", out_of(1), -640);
    held = longint'(data_out);
    idle_check(3);
    chk("data_out_held", longint'(data_out), held);

    run_op(1, 0, 1);
    chk("relu_out1", out_of(1), 0);
    idle_check(1);
    run_op(2, 0, 1);
    chk("step_out0", out_of(0), 256);
    chk("step_out1", out_of(1), 0);
    idle_check(1);

    for (int i = 0; i < D; i++) begin
      xs[i] = 32512; ws[i][0] = 32512; ws[i][1] = int'($urandom_range(0, 65535)) - 32768;
    end
    run_op(0, 0, 1);
`ifdef NEURON_LAYER_SAT_EN
    chk("ovf_out0", out_of(0), 32767);
`else
    chk("ovf_out0", out_of(0), 1024);
`endif
    idle_check(1);

    set_scenario1();
    gaps[2] = 3;
    run_op(0, 0, 0);
    idle_check(1);

    set_scenario1();
    run_op(0, 1, 1);
    idle_check(1);

    // Abort after two accepts.
    st = 1'b1; mode = 2'b00;
    @(negedge clk);
    st = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x_valid = 1'b1; x = N'(xs[i]); weight = {N'(ws[i][1]), N'(ws[i][0])};
      @(negedge clk);
    end
    x_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_data_out", longint'(data_out), 0);
    chk("abort_busy", busy, 0);
    chk("abort_x_ready", x_ready, 0);
    ndone = 0;
    for (int j = 0; j < 8; j++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);
    run_op(0, 0, 1);

    // Back-to-back: st in the done cycle with fresh data.
    for (int i = 0; i < D; i++) begin
      xs[i] = int'($urandom_range(0, 2047)) - 1024;
      ws[i][0] = int'($urandom_range(0, 2047)) - 1024;
      ws[i][1] = int'($urandom_range(0, 2047)) - 1024;
    end
    run_op(0, 0, 1);
    idle_check(2);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < D; i++) begin
        if (t % 3 == 0) begin
          xs[i] = int'($urandom_range(0, 65535)) - 32768;
          ws[i][0] = int'($urandom_range(0, 65535)) - 32768;
          ws[i][1] = int'($urandom_range(0, 65535)) - 32768;
        end else begin
          xs[i] = int'($urandom_range(0, 4095)) - 2048;
          ws[i][0] = int'($urandom_range(0, 4095)) - 2048;
          ws[i][1] = int'($urandom_range(0, 4095)) - 2048;
        end
        gaps[i] = $urandom_range(0, 2);
      end
      run_op(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 0);
      idle_check($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
